idu_exu_seq: RTL
================

# idu_exu_seq

Parametrised, multi-cycle decode/execute unit for the single-issue RV core. It accepts one 32-bit instruction per valid/ready handshake and decodes it with sign-extended immediates. It executes the RV integer immediate/upper/jump subset and writes back to an embedded register file. It owns the architectural PC and the ebreak/illegal halt state, and sits between the fetch unit and the simulation trace/halt monitor.

## Interface
- XLEN, 64, datapath width; 32 or 64 only.
- NR_REGS, 32, architectural register count; 32 (RV-I) or 16 (RV-E).
- RESET_PC, 64'h8000_0000, PC value after reset, truncated to XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- inst_valid  in  1  fetch presents an instruction.
- inst_ready  out  1  unit accepts an instruction this cycle.
- inst  in  32  instruction word, sampled on handshake.
- pc  out  XLEN  PC of the next instruction to fetch.
- wb_en  out  1  one-cycle pulse: register write this cycle.
- wb_addr  out  5  destination register.
- wb_data  out  XLEN  value written.
- halt  out  1  sticky: ebreak or illegal reached.
- illegal  out  1  sticky: halt was caused by an illegal instruction.
- halt_code  out  XLEN  value of x10 (a0) captured at halt.

## Operation
- FSM states: IDLE, EXEC, WB, HALT. Reset state is IDLE.
- IDLE: inst_ready=1. On inst_valid&&inst_ready, the unit latches inst and moves to EXEC.
- EXEC: the unit decodes, reads rs1, and computes the result and next PC into registers. It then moves to WB, or to HALT on ebreak or illegal.
- WB: wb_en=1 if the instruction writes and rd!=0. On exit from WB, the register file is written, pc is updated, and the FSM returns to IDLE.
- HALT: absorbing until rst_n. inst_ready=0 and wb_en=0. halt_code is captured on entry.
- Supported instructions:
  - addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - lui, auipc, jal, jalr, ebreak.
  - XLEN=64 only: addiw, slliw, srliw, sraiw. The result is 32-bit and sign-extended to 64.
- Immediates are always sign-extended from bit 31:
  - I: inst[31:20].
  - U: inst[31:12]<<12.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- Shift amount:
  - Uses shamt[5:0] when XLEN=64, shamt[4:0] otherwise.
  - Illegal if inst[25]=1 when XLEN=32.
  - Illegal if inst[25]=1 for any *w shift.
  - srai/sraiw require funct7 bits [30]=1 and other high bits 0; any other funct7 pattern is illegal.
- jal/jalr:
  - rd gets pc+4.
  - jalr target = (rs1+imm)&~1.
  - A target with bit1 set is illegal: no write, and pc is unchanged.
- Non-jump instructions: pc+=4. All arithmetic wraps modulo 2^XLEN.
- Illegal instructions:
  - Any opcode or funct3 outside the supported list, or inst[1:0]!=2'b11.
  - Any reference to rd or rs1 ≥ NR_REGS.
- x0 reads as 0. Writes to x0 are dropped and do not pulse wb_en.

## Timing
- The handshake occurs at edge E0. Cycle 1 is EXEC and cycle 2 is WB. wb_en/wb_addr/wb_data are valid during cycle 2.
- The register write and the pc update take effect at edge E2. inst_ready is 1 again in cycle 3.
- Throughput is one instruction per 3 cycles.
- Reset values:
  - pc=RESET_PC.
  - inst_ready=1.
  - wb_en=0, wb_addr=0, wb_data=0.
  - halt=0, illegal=0, halt_code=0.
  - All registers cleared to 0.
- Asserting rst_n low mid-instruction (EXEC or WB) immediately aborts the instruction: no register write and no pc update.
- inst_valid while inst_ready=0 is ignored; fetch must hold the instruction.
- halt rises at the edge that leaves EXEC for HALT.

## Structure
- Shared package (rv_pkg) holds:
  - Opcode constants OP_IMM, OP_IMM_32, LUI, AUIPC, JAL, JALR, SYSTEM.
  - funct3 constants.
  - FSM state enum.
  - Immediate-type enum (I, U, J).
- Sub-module rv_regfile:
  - Parameters XLEN and NR_REGS.
  - One asynchronous read port and one synchronous write port.
  - x0 hardwired to 0, with asynchronous clear on rst_n.
- The ALU stays inline.

## Test plan
- Reset, then `addi x1,x0,-1` (0xFFF00093) -> wb cycle 2: wb_addr=1, wb_data=0xFFFF_FFFF_FFFF_FFFF; pc=0x8000_0004.
- `lui x2,0x80000` then `addiw x3,x2,-1` (XLEN=64) -> x2=0xFFFF_FFFF_8000_0000; x3=0x0000_0000_7FFF_FFFF.
- `jal x1,+16` at 0x8000_0000 -> x1=0x8000_0004; pc=0x8000_0010. Then `jalr x0,0(x1)` -> no wb_en; pc=0x8000_0004.
- Set x10=42, then `ebreak` (0x00100073) -> halt=1, illegal=0, halt_code=42; later inst_valid is ignored with inst_ready=0.
- Illegal cases -> each gives halt=1 and illegal=1 with no wb_en:
  - 0x0000_0000.
  - slli with shamt=32 at XLEN=32.
  - Any rd=17 at NR_REGS=16.
- Drop rst_n during WB of `addi x5,x0,7` -> x5=0, pc=RESET_PC; the next instruction proceeds normally.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared encodings, FSM states and immediate helpers
// for the decode/execute stage.
package rv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_U,
        IMM_J
    } imm_e;

    function automatic logic [63:0] imm_gen(
        input logic [31:0] i,
        input imm_e        t
    );
        case (t)
            IMM_U:   imm_gen = {{32{i[31]}}, i[31:12], 12'b0};
            IMM_J:   imm_gen = {{43{i[31]}}, i[31], i[19:12],
                                i[20], i[30:21], 1'b0};
            default: imm_gen = {{52{i[31]}}, i[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/idu_exu_seq_if.sv
// Fetch-to-decode instruction handshake.
interface idu_exu_seq_if;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;

    modport master (
        output inst_valid,
        output inst,
        input  inst_ready
    );

    modport slave (
        input  inst_valid,
        input  inst,
        output inst_ready
    );

endinterface

// File: rtl/rv_regfile.sv
// Integer register file: one async read port, one sync write
// port, x0 hardwired to zero, plus a fixed a0 tap for halt.
module rv_regfile #(
    parameter int XLEN    = 64,
    parameter int NR_REGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      i_raddr,
    output logic [XLEN-1:0] o_rdata,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_a0
);

    localparam int AW = $clog2(NR_REGS);

    logic [XLEN-1:0] r_regs [NR_REGS];
    logic            w_rok;
    logic            w_wok;

    assign w_rok = ({1'b0, i_raddr} < 6'(NR_REGS))
                && (i_raddr != 5'd0);
    assign w_wok = ({1'b0, i_waddr} < 6'(NR_REGS))
                && (i_waddr != 5'd0);

    assign o_rdata = w_rok ? r_regs[i_raddr[AW-1:0]] : '0;
    assign o_a0    = r_regs[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && w_wok) begin
            r_regs[i_waddr[AW-1:0]] <= i_wdata;
        end
    end

endmodule

// File: rtl/idu_exu_seq.sv
// Multi-cycle decode/execute for the RV integer immediate,
// upper and jump subset; owns the PC and the halt state.
module idu_exu_seq
    import rv_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          NR_REGS  = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    idu_exu_seq_if.slave    fetch,
    output logic [XLEN-1:0] pc,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            halt,
    output logic            illegal,
    output logic [XLEN-1:0] halt_code
);

    localparam logic [XLEN-1:0] PC0 = RESET_PC[XLEN-1:0];

    state_e          r_state;
    logic [31:0]     r_inst;
    logic            r_ready;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_npc;
    logic            r_wb_en;
    logic [4:0]      r_wb_addr;
    logic [XLEN-1:0] r_wb_data;
    logic            r_halt;
    logic            r_illegal;
    logic [XLEN-1:0] r_halt_code;

    logic [6:0]      w_op;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1a;
    logic [5:0]      w_f7hi;
    logic            w_ebreak;
    imm_e            w_imm_sel;
    logic [63:0]     w_imm64;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_a0;
    logic [5:0]      w_shamt;
    logic            w_bad25;
    logic [XLEN-1:0] w_sra;
    logic [31:0]     w_sraw;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_jsum;
    logic            w_rd_oob;
    logic            w_rs1_oob;
    logic            w_we;
    logic [31:0]     w_w32;
    logic [XLEN-1:0] w_res;
    logic [XLEN-1:0] w_npc;
    logic            w_wr;
    logic            w_ill;
    logic            w_use_rs1;

    assign w_op     = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_f3     = r_inst[14:12];
    assign w_rs1a   = r_inst[19:15];
    assign w_f7hi   = r_inst[31:26];
    assign w_ebreak = (r_inst == EBREAK);

    assign w_imm_sel = (w_op == LUI || w_op == AUIPC) ? IMM_U :
                       (w_op == JAL)                  ? IMM_J :
                                                        IMM_I;
    assign w_imm64 = imm_gen(r_inst, w_imm_sel);
    assign w_imm   = w_imm64[XLEN-1:0];

    // shamt[5] only exists on RV64; on RV32 that bit must be zero
    assign w_shamt = (XLEN == 64) ? r_inst[25:20]
                                  : {1'b0, r_inst[24:20]};
    assign w_bad25 = (XLEN != 64) && r_inst[25];
    assign w_sra   = $signed(w_rs1) >>> w_shamt;
    assign w_sraw  = $signed(w_rs1[31:0]) >>> r_inst[24:20];
    assign w_pc4   = r_pc + XLEN'(4);
    assign w_jsum  = w_rs1 + w_imm;

    assign w_rd_oob  = {1'b0, w_rd} >= 6'(NR_REGS);
    assign w_rs1_oob = {1'b0, w_rs1a} >= 6'(NR_REGS);

    always_comb begin
        w_res     = '0;
        w_npc     = w_pc4;
        w_wr      = 1'b0;
        w_ill     = 1'b0;
        w_use_rs1 = 1'b0;
        w_w32     = '0;
        unique case (1'b1)
            (w_op == OP_IMM): begin
                w_wr      = 1'b1;
                w_use_rs1 = 1'b1;
                unique case (w_f3)
                    F3_ADD:  w_res = w_rs1 + w_imm;
                    F3_SLT:  w_res = XLEN'($signed(w_rs1) < $signed(w_imm));
                    F3_SLTU: w_res = XLEN'(w_rs1 < w_imm);
                    F3_XOR:  w_res = w_rs1 ^ w_imm;
                    F3_OR:   w_res = w_rs1 | w_imm;
                    F3_AND:  w_res = w_rs1 & w_imm;
                    F3_SLL: begin
                        w_res = w_rs1 << w_shamt;
                        w_ill = (w_f7hi != 6'd0) || w_bad25;
                    end
                    F3_SR: begin
                        w_res = r_inst[30] ? w_sra : (w_rs1 >> w_shamt);
                        w_ill = ((w_f7hi & 6'b101111) != 6'd0) || w_bad25;
                    end
                endcase
            end
            (w_op == OP_IMM_32): begin
                w_wr      = 1'b1;
                w_use_rs1 = 1'b1;
                w_ill     = (XLEN != 64);
                unique case (w_f3)
                    F3_ADD: w_w32 = w_rs1[31:0] + w_imm[31:0];
                    F3_SLL: begin
                        w_w32 = w_rs1[31:0] << r_inst[24:20];
                        w_ill = w_ill || (r_inst[31:25] != 7'd0);
                    end
                    F3_SR: begin
                        w_w32 = r_inst[30] ? w_sraw
                                           : (w_rs1[31:0] >> r_inst[24:20]);
                        w_ill = w_ill
                             || ((r_inst[31:25] & 7'b1011111) != 7'd0);
                    end
                    default: w_ill = 1'b1;
                endcase
                w_res = XLEN'(signed'(w_w32));
            end
            (w_op == LUI): begin
                w_wr  = 1'b1;
                w_res = w_imm;
            end
            (w_op == AUIPC): begin
                w_wr  = 1'b1;
                w_res = r_pc + w_imm;
            end
            (w_op == JAL): begin
                w_wr  = 1'b1;
                w_res = w_pc4;
                w_npc = r_pc + w_imm;
                w_ill = w_npc[1];
            end
            (w_op == JALR): begin
                w_wr      = 1'b1;
                w_use_rs1 = 1'b1;
                w_res     = w_pc4;
                w_npc     = {w_jsum[XLEN-1:1], 1'b0};
                w_ill     = (w_f3 != 3'd0) || w_npc[1];
            end
            (w_op == SYSTEM): w_ill = !w_ebreak;
            default:          w_ill = 1'b1;
        endcase
        if (!w_ebreak && (w_rd_oob || (w_use_rs1 && w_rs1_oob))) begin
            w_ill = 1'b1;
        end
    end

    assign w_we = (r_state == S_WB) && r_wb_en;

    rv_regfile #(
        .XLEN    (XLEN),
        .NR_REGS (NR_REGS)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raddr (w_rs1a),
        .o_rdata (w_rs1),
        .i_we    (w_we),
        .i_waddr (r_wb_addr),
        .i_wdata (r_wb_data),
        .o_a0    (w_a0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_inst      <= '0;
            r_ready     <= 1'b1;
            r_pc        <= PC0;
            r_npc       <= PC0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_halt      <= 1'b0;
            r_illegal   <= 1'b0;
            r_halt_code <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (fetch.inst_valid && r_ready) begin
                        r_inst  <= fetch.inst;
                        r_ready <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_ebreak || w_ill) begin
                        r_state     <= S_HALT;
                        r_halt      <= 1'b1;
                        r_illegal   <= w_ill;
                        r_halt_code <= w_a0;
                    end else begin
                        r_state   <= S_WB;
                        r_wb_en   <= w_wr && (w_rd != 5'd0);
                        r_wb_addr <= w_rd;
                        r_wb_data <= w_res;
                        r_npc     <= w_npc;
                    end
                end
                S_WB: begin
                    r_wb_en <= 1'b0;
                    r_pc    <= r_npc;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_HALT: r_state <= S_HALT;
            endcase
        end
    end

    assign fetch.inst_ready = r_ready;
    assign pc        = r_pc;
    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign halt      = r_halt;
    assign illegal   = r_illegal;
    assign halt_code = r_halt_code;

endmodule
